// File: rtl/seq_det_pkg.sv
// Shared constants, types and the masked comparison used by the serial pattern detector.
package seq_det_pkg;

  localparam logic [7:0] HDLC_FLAG = 8'h7E;
  localparam int         MAX_N     = 32;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } match_mode_e;

  // Operands are zero-extended to MAX_N by the caller, so unused upper bits compare equal.
  function automatic logic masked_eq(input logic [MAX_N-1:0] history,
                                     input logic [MAX_N-1:0] pattern,
                                     input logic [MAX_N-1:0] mask);
    return ((history ^ pattern) & mask) == '0;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a synchronous clear takes priority over an increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detector_n.sv
// Serial pattern detector: compares the last N accepted bits against a programmable,
// maskable pattern and emits a registered one-cycle find pulse plus a saturating count.
module seq_detector_n
  import seq_det_pkg::*;
#(
  parameter int             N               = 8,
  parameter logic [N-1:0]   DEFAULT_PATTERN = N'(HDLC_FLAG),
  parameter int             CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [N-1:0]     cfg_mask,
  input  logic             cnt_clr,
  output logic             find,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  localparam int             FW        = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]  history_q, history_d;
  logic [N-1:0]  pattern_q, pattern_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          find_q, find_d;
  logic [FW-1:0] fill_inc;
  logic          match;
  match_mode_e   mode;

  assign mode     = match_mode_e'(overlap);
  assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

  // Stream has no back-pressure: a bit is taken on every edge where in_valid is high,
  // unless cfg_load is also high, in which case the bit is dropped.
  always_comb begin
    history_d = history_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    fill_d    = fill_q;
    find_d    = 1'b0;
    match     = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      fill_d    = '0;
    end else if (in_valid) begin
      history_d = {history_q[N-2:0], in};
      fill_d    = fill_inc;
      match     = (fill_inc == FILL_FULL) &&
                  masked_eq(MAX_N'(history_d), MAX_N'(pattern_q), MAX_N'(mask_q));
      find_d    = match;
      // Non-overlapping mode restarts the history window after every hit.
      if (match && (mode == NON_OVERLAP)) begin
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history_q <= '0;
      pattern_q <= DEFAULT_PATTERN;
      mask_q    <= '1;
      fill_q    <= '0;
      find_q    <= 1'b0;
    end else begin
      history_q <= history_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      fill_q    <= fill_d;
      find_q    <= find_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (cnt_clr),
    .q   (match_cnt)
  );

  assign find = find_q;
  assign busy = (fill_q < FILL_FULL);

endmodule

// File: tb/tb_seq_detector_n.sv
// Directed bench for seq_detector_n (N=8, default flag 0x7E, 4-bit match counter).
module tb_seq_detector_n;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             din;
  logic             in_valid;
  logic             overlap;
  logic             cfg_load;
  logic [N-1:0]     cfg_pattern;
  logic [N-1:0]     cfg_mask;
  logic             cnt_clr;
  logic             find;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  seq_detector_n #(.N(N), .DEFAULT_PATTERN(8'h7E), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (din),
    .in_valid    (in_valid),
    .overlap     (overlap),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cnt_clr     (cnt_clr),
    .find        (find),
    .match_cnt   (match_cnt),
    .busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_find, input string tag);
    in_valid = 1'b1;
    din      = b;
    tick();
    in_valid = 1'b0;
    din      = ~b;
    check(tag, 32'(find), 32'(exp_find));
  endtask

  task automatic load_cfg(input logic [N-1:0] pat, input logic [N-1:0] msk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_mask    = msk;
    tick();
    cfg_load = 1'b0;
  endtask

  logic [7:0]  flag;
  logic [14:0] two_flags;
  logic [7:0]  a_stream;
  int          exp_cnt;

  initial begin
    flag      = 8'h7E;
    two_flags = 15'b011111101111110;
    a_stream  = 8'b10101101;
    rst = 1'b1; din = 1'b0; in_valid = 1'b0; overlap = 1'b1;
    cfg_load = 1'b0; cfg_pattern = '0; cfg_mask = '0; cnt_clr = 1'b0;
    #3;
    check("rst_find", 32'(find), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;

    // single flag, overlap mode
    for (int i = 0; i < 8; i++) begin
      send(flag[7-i], (i == 7), "flag_find");
      check("flag_busy", 32'(busy), 32'(i < 7));
    end
    check("flag_cnt", 32'(match_cnt), 32'd1);
    tick();
    check("flag_find_idle", 32'(find), 32'd0);

    // shared-zero double flag, overlapping
    sync_reset();
    overlap = 1'b1;
    for (int i = 0; i < 15; i++) send(two_flags[14-i], (i == 7) || (i == 14), "ovl_find");
    check("ovl_cnt", 32'(match_cnt), 32'd2);

    // same stream, non-overlapping
    sync_reset();
    overlap = 1'b0;
    for (int i = 0; i < 15; i++) send(two_flags[14-i], (i == 7), "novl_find");
    check("novl_cnt", 32'(match_cnt), 32'd1);

    // flag with an idle gap and toggling data
    sync_reset();
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) send(flag[7-i], 1'b0, "gap_find");
    for (int g = 0; g < 3; g++) begin
      din = g[0];
      tick();
      check("gap_idle_find", 32'(find), 32'd0);
      check("gap_idle_busy", 32'(busy), 32'd1);
    end
    for (int i = 4; i < 8; i++) send(flag[7-i], (i == 7), "gap_find");
    check("gap_cnt", 32'(match_cnt), 32'd1);

    // masked pattern, then cfg_load colliding with a valid bit
    sync_reset();
    load_cfg(8'hA0, 8'hF0);
    check("cfg_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send(a_stream[7-i], (i == 7), "mask_find");
    cfg_load = 1'b1; cfg_pattern = 8'hA0; cfg_mask = 8'hF0;
    in_valid = 1'b1; din = 1'b1;
    tick();
    cfg_load = 1'b0; in_valid = 1'b0;
    check("cfg_drop_find", 32'(find), 32'd0);
    check("cfg_drop_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send(a_stream[7-i], (i == 7), "mask2_find");
      check("mask2_busy", 32'(busy), 32'(i < 7));
    end
    check("mask_cnt", 32'(match_cnt), 32'd2);

    // all don't-care: every bit matches once the window is full
    sync_reset();
    load_cfg(8'h00, 8'h00);
    for (int i = 0; i < 10; i++) send(i[0], (i >= 7), "dc_find");
    check("dc_cnt", 32'(match_cnt), 32'd3);

    // saturation over 17 back-to-back flags
    sync_reset();
    overlap = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < 8; i++) send(flag[7-i], (i == 7), "sat_find");
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      check("sat_cnt", 32'(match_cnt), 32'(exp_cnt));
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt", 32'(match_cnt), 32'd0);
    for (int i = 0; i < 7; i++) send(flag[7-i], 1'b0, "clr_pre_find");
    cnt_clr = 1'b1;
    send(flag[0], 1'b1, "clr_match_find");
    cnt_clr = 1'b0;
    check("clr_match_cnt", 32'(match_cnt), 32'd0);

    // asynchronous reset mid-stream restores the default flag
    sync_reset();
    for (int i = 0; i < 8; i++) send(flag[7-i], (i == 7), "ar_pre_find");
    check("ar_pre_cnt", 32'(match_cnt), 32'd1);
    load_cfg(8'hA0, 8'hF0);
    for (int i = 0; i < 5; i++) send(flag[7-i], 1'b0, "ar_part_find");
    #3;
    rst = 1'b1;
    #1;
    check("ar_cnt", 32'(match_cnt), 32'd0);
    check("ar_busy", 32'(busy), 32'd1);
    check("ar_find", 32'(find), 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 5; i < 8; i++) begin
      send(flag[7-i], 1'b0, "ar_tail_find");
      check("ar_tail_busy", 32'(busy), 32'd1);
    end
    for (int i = 0; i < 8; i++) send(flag[7-i], (i == 7), "ar_post_find");
    check("ar_post_cnt", 32'(match_cnt), 32'd1);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
